spi_reg_bank: RTL

- Parametrised successor to the FIR chip's SPI coefficient loader.
- Holds NUM_REGS x DATA_W coefficient registers internally and drives them out in parallel to the FIR datapath.
- Adds burst read and burst write with address auto-increment, a status byte, range and command error detection, and an error-clear command.
- Slave-only. All logic is clocked by SCK falling edges.

---
 rtl/spi_reg_bank_if.sv | 9 +
 rtl/spi_reg_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// SPI serial lines between the FIR controller (master) and the coefficient bank (slave).
interface spi_reg_bank_if;
    logic CS;
    logic MOSI;
    logic MISO;

    modport master (output CS, output MOSI, input MISO);
    modport slave  (input CS, input MOSI, output MISO);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-loaded coefficient register bank with burst read/write, status byte and sticky error flag.
// Everything runs on SCK falling edges; CS high asynchronously clears the frame logic only.
module spi_reg_bank #(
    parameter int         DATA_W    = 12,
    parameter int         NUM_REGS  = 32,
    parameter logic [7:0] WRITE_CMD = 8'hFB,
    parameter logic [7:0] READ_CMD  = 8'hFC,
    parameter logic [7:0] CLR_CMD   = 8'hFD
) (
    input  logic                         SCK,
    input  logic                         Reset_n,
    spi_reg_bank_if.slave                spi,
    output logic                         load,
    output logic [7:0]                   register_address,
    output logic [DATA_W-1:0]            register_value,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         err
);

    localparam int DATA_BYTES = (DATA_W + 7) / 8;
    localparam int WORD_W     = DATA_BYTES * 8;
    localparam int CNT_W      = $clog2(WORD_W);
    localparam int RX_W       = (DATA_W > 8) ? DATA_W : 8;
    localparam logic [8:0] NUM_REGS_9 = 9'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DRAIN} state_t;

    state_t                state, state_nx;
    logic                  frame_rst_n;
    logic [RX_W-2:0]       rx;
    logic [RX_W-1:0]       rx_nx;
    logic [WORD_W-1:0]     tx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [7:0]            cmd_q, addr_q, rd_addr;
    logic                  byte_end, word_end;
    logic                  cmd_done, addr_done, wr_strobe, rd_strobe, rd_load;
    logic                  rd_ok, wr_ok;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == WRITE_CMD) || (c == READ_CMD) || (c == CLR_CMD);
    endfunction

    // Frame logic is held cleared whenever the chip is deselected or in reset.
    assign frame_rst_n = Reset_n & ~spi.CS;
    assign rx_nx       = {rx, spi.MOSI};
    assign byte_end    = (cnt == CNT_W'(7));
    assign word_end    = (cnt == CNT_W'(WORD_W - 1));
    assign spi.MISO    = tx[WORD_W-1];

    always_ff @(negedge SCK or negedge frame_rst_n) begin
        if (!frame_rst_n) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        cmd_done  = 1'b0;
        addr_done = 1'b0;
        wr_strobe = 1'b0;
        rd_strobe = 1'b0;
        case (state)
            IDLE: state_nx = CMD;
            CMD: if (byte_end) begin
                cmd_done = 1'b1;
                cnt_nx   = '0;
                state_nx = ADDR;
            end
            ADDR: if (byte_end) begin
                addr_done = 1'b1;
                cnt_nx    = '0;
                if (cmd_q == WRITE_CMD)     state_nx = WDATA;
                else if (cmd_q == READ_CMD) state_nx = RDATA;
                else                        state_nx = DRAIN;
            end
            WDATA: if (word_end) begin
                wr_strobe = 1'b1;
                cnt_nx    = '0;
            end
            RDATA: if (word_end) begin
                rd_strobe = 1'b1;
                cnt_nx    = '0;
            end
            DRAIN: cnt_nx = cnt;
            default: state_nx = IDLE;
        endcase
    end

    // The first read address comes straight off the shifter so no turnaround byte is needed.
    assign rd_addr = (state == ADDR) ? rx_nx[7:0] : addr_q;
    assign rd_load = (addr_done && (cmd_q == READ_CMD)) || rd_strobe;
    assign rd_ok   = {1'b0, rd_addr} < NUM_REGS_9;
    assign wr_ok   = {1'b0, addr_q} < NUM_REGS_9;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 8'(i)) rd_word = regs[i];
    end

    always_ff @(negedge SCK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            rx     <= '0;
            tx     <= '0;
            cnt    <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
        end else begin
            rx  <= rx_nx[RX_W-2:0];
            cnt <= cnt_nx;
            tx  <= tx << 1;
            if (cmd_done) begin
                cmd_q <= rx_nx[7:0];
                tx    <= WORD_W'({4'hA, 3'b000, err}) << (WORD_W - 8);
            end
            if (addr_done)
                addr_q <= (cmd_q == READ_CMD) ? rx_nx[7:0] + 8'd1 : rx_nx[7:0];
            if (wr_strobe || rd_strobe)
                addr_q <= addr_q + 8'd1;
            if (rd_load)
                tx <= rd_ok ? WORD_W'(rd_word) : '0;
        end
    end

    // Persistent state survives deselect; only Reset_n clears it.
    always_ff @(negedge SCK or negedge Reset_n) begin
        if (!Reset_n) begin
            load             <= 1'b0;
            register_address <= '0;
            register_value   <= '0;
            err              <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            load <= 1'b0;
            if (cmd_done && !cmd_known(rx_nx[7:0])) err <= 1'b1;
            if (addr_done && (cmd_q == CLR_CMD))    err <= 1'b0;
            if (rd_load && !rd_ok)                  err <= 1'b1;
            if (wr_strobe) begin
                if (wr_ok) begin
                    load             <= 1'b1;
                    register_address <= addr_q;
                    register_value   <= rx_nx[DATA_W-1:0];
                    for (int i = 0; i < NUM_REGS; i++)
                        if (addr_q == 8'(i)) regs[i] <= rx_nx[DATA_W-1:0];
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
